// File: rtl/ks_memory.sv
// ks_memory: 32x16 word store with a single-access request/ready port and an
// optional boot loader (KS_MEMORY_BOOTLOAD_EN) that fills the image after reset.
module ks_memory (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ram_addr,
  input  logic [15:0] ram_wdata,
  input  logic        ram_write_enable,
  input  logic        ram_req,
  output logic        ram_ready,
  output logic [15:0] ram_rdata,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  output logic        load_done
);

  typedef enum logic [1:0] {LOAD, IDLE, RESP} state_t;

  state_t            state;
  logic [31:0][15:0] mem;

`ifdef KS_MEMORY_BOOTLOAD_EN
  logic [4:0] load_cnt;

  assign load_ready = (state == LOAD);
  assign load_done  = (state != LOAD);
`else
  logic unused_load;

  assign unused_load = ^{load_valid, load_data};
  assign load_ready  = 1'b0;
  assign load_done   = 1'b1;
`endif

  // Memory words reset with the rest of the state so an aborted load or
  // access never leaves a partial image behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef KS_MEMORY_BOOTLOAD_EN
      state    <= LOAD;
      load_cnt <= '0;
`else
      state    <= IDLE;
`endif
      ram_ready <= 1'b0;
      ram_rdata <= '0;
      mem       <= '0;
    end else begin
      case (state)
`ifdef KS_MEMORY_BOOTLOAD_EN
        LOAD: begin
          ram_ready <= 1'b0;
          if (load_valid) begin
            mem[load_cnt] <= load_data;
            load_cnt      <= load_cnt + 5'd1;
            if (load_cnt == 5'd31) state <= IDLE;
          end
        end
`endif
        IDLE: begin
          if (ram_req) begin
            state     <= RESP;
            ram_ready <= 1'b1;
            if (ram_write_enable) mem[ram_addr] <= ram_wdata;
            else                  ram_rdata     <= mem[ram_addr];
          end
        end
        RESP: begin
          // Requests seen here wait for the following IDLE cycle.
          state     <= IDLE;
          ram_ready <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          ram_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ks_memory.sv
// Directed bench for ks_memory; covers the boot loader when
// KS_MEMORY_BOOTLOAD_EN is defined, otherwise the direct-to-IDLE build.
module tb_ks_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_write_enable;
  logic        ram_req;
  logic        ram_ready;
  logic [15:0] ram_rdata;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        load_done;

  int checks = 0;
  int errors = 0;

  ks_memory dut (
    .clk(clk), .rst(rst),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_write_enable(ram_write_enable), .ram_req(ram_req),
    .ram_ready(ram_ready), .ram_rdata(ram_rdata),
    .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full handshake: request at a negedge, ready expected one cycle later,
  // then a quiet cycle with ram_rdata holding.
  task automatic access(input logic we, input logic [4:0] a, input logic [15:0] wd,
                        input logic [15:0] exp_rd, input string tag);
    @(negedge clk);
    ram_req = 1'b1; ram_write_enable = we; ram_addr = a; ram_wdata = wd;
    chk({tag, "_ready_before"}, {15'd0, ram_ready}, 16'd0);
    @(negedge clk);
    chk({tag, "_ready"}, {15'd0, ram_ready}, 16'd1);
    chk({tag, "_rdata"}, ram_rdata, exp_rd);
    ram_req = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_drop"}, {15'd0, ram_ready}, 16'd0);
    chk({tag, "_rdata_hold"}, ram_rdata, exp_rd);
  endtask

`ifdef KS_MEMORY_BOOTLOAD_EN
  // Streams n words base+i with load_valid held; optionally pokes ram_req at word 10.
  task automatic load_words(input int n, input logic [15:0] base, input bit poke);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("load_ready", {15'd0, load_ready}, 16'd1);
      chk("load_done_low", {15'd0, load_done}, 16'd0);
      chk("ready_in_load", {15'd0, ram_ready}, 16'd0);
      load_valid = 1'b1;
      load_data  = base + 16'(i);
      ram_req = (poke && i == 10);
      ram_write_enable = 1'b1; ram_addr = 5'd0; ram_wdata = 16'hFFFF;
    end
    @(negedge clk);
    load_valid = 1'b0;
    ram_req = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    ram_addr = '0; ram_wdata = '0; ram_write_enable = 1'b0; ram_req = 1'b0;
    load_valid = 1'b0; load_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {15'd0, ram_ready}, 16'd0);
    chk("rst_rdata", ram_rdata, 16'h0000);
    rst = 1'b0;

`ifdef KS_MEMORY_BOOTLOAD_EN
    chk("boot_load_done", {15'd0, load_done}, 16'd0);
    chk("boot_load_ready", {15'd0, load_ready}, 16'd1);
    // Partial load with an access attempt at load_cnt=10, then reset at load_cnt=12.
    load_words(12, 16'h0200, 1'b1);
    // The extra negedge inside load_words left load_cnt at 12.
    rst = 1'b1;
    @(negedge clk);
    chk("midload_rst_done", {15'd0, load_done}, 16'd0);
    chk("midload_rst_rdy", {15'd0, load_ready}, 16'd1);
    rst = 1'b0;
    load_words(32, 16'h0100, 1'b0);
    chk("load_done_high", {15'd0, load_done}, 16'd1);
    chk("load_ready_low", {15'd0, load_ready}, 16'd0);
    access(1'b0, 5'd0,  16'h0, 16'h0100, "boot_rd0");
    access(1'b0, 5'd10, 16'h0, 16'h010A, "boot_rd10");
    access(1'b0, 5'd17, 16'h0, 16'h0111, "boot_rd17");
    access(1'b0, 5'd31, 16'h0, 16'h011F, "boot_rd31");
`else
    chk("nb_load_done", {15'd0, load_done}, 16'd1);
    chk("nb_load_ready", {15'd0, load_ready}, 16'd0);
    // load_valid must be ignored without the loader.
    load_valid = 1'b1; load_data = 16'h5555;
    access(1'b0, 5'd9, 16'h0, 16'h0000, "nb_rd9");
    load_valid = 1'b0;
    access(1'b0, 5'd0, 16'h0, 16'h0000, "nb_rd0");
`endif

    // Write then read: rdata keeps the previous read value through the write response.
    access(1'b0, 5'd5, 16'h0, dut_expect_5(), "pre_rd5");
    access(1'b1, 5'd5, 16'hBEEF, dut_expect_5(), "wr5");
    access(1'b0, 5'd5, 16'h0, 16'hBEEF, "rd5");
    access(1'b1, 5'd3, 16'h1111, 16'hBEEF, "wr3");
    access(1'b1, 5'd4, 16'h2222, 16'hBEEF, "wr4");
    access(1'b1, 5'd31, 16'hA5A5, 16'hBEEF, "wr31");
    access(1'b1, 5'd0, 16'h0F0F, 16'hBEEF, "wr0");
    access(1'b0, 5'd31, 16'h0, 16'hA5A5, "rd31");
    access(1'b0, 5'd0, 16'h0, 16'h0F0F, "rd0");

    // Back-to-back reads with ram_req held: accept at n and n+2 only.
    @(negedge clk);
    ram_req = 1'b1; ram_write_enable = 1'b0; ram_addr = 5'd3;
    @(negedge clk);
    chk("b2b_ready_n1", {15'd0, ram_ready}, 16'd1);
    chk("b2b_rdata_n1", ram_rdata, 16'h1111);
    ram_addr = 5'd4;
    @(negedge clk);
    chk("b2b_ready_n2", {15'd0, ram_ready}, 16'd0);
    chk("b2b_rdata_n2", ram_rdata, 16'h1111);
    @(negedge clk);
    chk("b2b_ready_n3", {15'd0, ram_ready}, 16'd1);
    chk("b2b_rdata_n3", ram_rdata, 16'h2222);
    ram_req = 1'b0;
    @(negedge clk);
    chk("b2b_ready_n4", {15'd0, ram_ready}, 16'd0);

    // Reset during a write response clears memory and outputs.
    @(negedge clk);
    ram_req = 1'b1; ram_write_enable = 1'b1; ram_addr = 5'd5; ram_wdata = 16'h1234;
    @(negedge clk);
    chk("abort_ready", {15'd0, ram_ready}, 16'd1);
    rst = 1'b1; ram_req = 1'b0;
    #1;
    chk("abort_ready_clr", {15'd0, ram_ready}, 16'd0);
    chk("abort_rdata_clr", ram_rdata, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
`ifdef KS_MEMORY_BOOTLOAD_EN
    chk("abort_load_done", {15'd0, load_done}, 16'd0);
    chk("abort_load_ready", {15'd0, load_ready}, 16'd1);
`else
    access(1'b0, 5'd5, 16'h0, 16'h0000, "abort_rd5");
    access(1'b0, 5'd31, 16'h0, 16'h0000, "abort_rd31");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Word 5 before any processor write: boot image value, or zero without the loader.
  function automatic logic [15:0] dut_expect_5();
`ifdef KS_MEMORY_BOOTLOAD_EN
    return 16'h0105;
`else
    return 16'h0000;
`endif
  endfunction

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
